// File: rtl/fetch_buffer_if.sv
// Handshake bundle between the PC stage / InstructionRAM and the fetch buffer.
// The buffer takes the slave side; the PC stage / test harness drives the master side.
interface fetch_buffer_if;
  logic [31:0] FETCH_ADDRESS;
  logic [31:0] PCplus4F;
  logic        fetch_valid;
  logic [31:0] instr_rdata;
  logic        flush;
  logic        stall;
  logic        fetch_ready;
  logic [31:0] instrD;
  logic [31:0] PCplus4D;
  logic        validD;
  logic [1:0]  count;
  logic        overflow_err;

  modport slave (
    input  FETCH_ADDRESS, PCplus4F, fetch_valid, instr_rdata, flush, stall,
    output fetch_ready, instrD, PCplus4D, validD, count, overflow_err
  );

  modport master (
    output FETCH_ADDRESS, PCplus4F, fetch_valid, instr_rdata, flush, stall,
    input  fetch_ready, instrD, PCplus4D, validD, count, overflow_err
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry instruction queue between fetch and decode with a single in-flight
// RAM read slot; flush redirects, stall holds the head, overflow is sticky.
module fetch_buffer (
  input  logic           CLOCK,
  input  logic           RESET,
  fetch_buffer_if.slave  fb
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t      q [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  cnt;
  logic        pend_valid;
  logic [31:0] pend_pc4;
  logic        ovf;

  logic [1:0]  occ;
  logic        head_vld;
  logic        deq;
  logic        enq;
  logic        ready;
  logic        issue;

  assign head_vld = (cnt != 2'd0);
  assign occ      = cnt + {1'b0, pend_valid};
  assign deq      = head_vld && !fb.stall;
  // A full slot set is still ready when the head leaves this cycle; a flush
  // empties everything, so the redirected fetch is always accepted.
  assign ready    = fb.flush || (occ <= 2'd1) || ((occ == 2'd2) && deq);
  assign issue    = fb.fetch_valid && ready;
  assign enq      = pend_valid && !fb.flush;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      q[0]       <= '0;
      q[1]       <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      cnt        <= 2'd0;
      pend_valid <= 1'b0;
      pend_pc4   <= '0;
      ovf        <= 1'b0;
    end else if (fb.flush) begin
      // Stale entries stay in storage but are invisible once cnt is zero.
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      cnt        <= 2'd0;
      pend_valid <= fb.fetch_valid;
      if (fb.fetch_valid) pend_pc4 <= fb.PCplus4F;
    end else begin
      if (enq) begin
        q[wr_ptr] <= entry_t'{instr: fb.instr_rdata, pc4: pend_pc4};
        wr_ptr    <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      cnt        <= cnt + {1'b0, enq} - {1'b0, deq};
      pend_valid <= issue;
      if (issue) pend_pc4 <= fb.PCplus4F;
      if (fb.fetch_valid && !ready) ovf <= 1'b1;
    end
  end

  assign fb.fetch_ready  = ready;
  assign fb.validD       = head_vld;
  assign fb.instrD       = head_vld ? q[rd_ptr].instr : '0;
  assign fb.PCplus4D     = head_vld ? q[rd_ptr].pc4   : '0;
  assign fb.count        = cnt;
  assign fb.overflow_err = ovf;

  // The address is only carried for protocol checking: an accepted fetch must present one.
  a_addr_known: assert property (@(posedge CLOCK) disable iff (RESET)
    issue |-> !$isunknown(fb.FETCH_ADDRESS));
  a_occ_bound: assert property (@(posedge CLOCK) disable iff (RESET)
    occ <= 2'd2);

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed scenarios for fetch_buffer: reset, streaming, backpressure, flush,
// protocol violation and reset mid-stream, each with hand-computed expectations.
module tb_fetch_buffer;
  logic CLOCK;
  logic RESET;
  int   checks;
  int   errors;

  fetch_buffer_if bus ();

  fetch_buffer dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .fb    (bus.slave)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic tick;
    @(posedge CLOCK);
    #2;
  endtask

  task automatic set_in(input logic fv, input logic [31:0] pc4, input logic [31:0] rd,
                        input logic st, input logic fl);
    bus.fetch_valid   = fv;
    bus.PCplus4F      = pc4;
    bus.FETCH_ADDRESS = {pc4[29:0], 2'b00};
    bus.instr_rdata   = rd;
    bus.stall         = st;
    bus.flush         = fl;
  endtask

  task automatic do_reset;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
  endtask

  task automatic test_reset;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    RESET = 1'b1;
    tick;
    tick;
    RESET = 1'b0;
    #1;
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    checks++; if (bus.validD !== 1'b0) begin errors++; $display("FAIL rst_validD got %b exp 0", bus.validD); end
    checks++; if (bus.instrD !== 32'h0) begin errors++; $display("FAIL rst_instrD got %h exp 0", bus.instrD); end
    checks++; if (bus.PCplus4D !== 32'h0) begin errors++; $display("FAIL rst_pc4D got %h exp 0", bus.PCplus4D); end
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", bus.overflow_err); end
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.fetch_ready); end
  endtask

  // Fetch every cycle, no stall: one instruction per cycle from cycle 2, count stays 1.
  task automatic test_back_to_back;
    logic [31:0] e;
    do_reset;
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, k + 1, 32'hA0 + k, 1'b0, 1'b0);
      #1;
      checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c%0d got %b exp 1", k, bus.fetch_ready); end
      tick;
      if (k + 1 >= 2) begin
        e = 32'hA0 + k;
        checks++; if (bus.validD !== 1'b1) begin errors++; $display("FAIL b2b_validD c%0d got %b exp 1", k + 1, bus.validD); end
        checks++; if (bus.instrD !== e) begin errors++; $display("FAIL b2b_instrD c%0d got %h exp %h", k + 1, bus.instrD, e); end
        checks++; if (bus.PCplus4D !== 32'(k)) begin errors++; $display("FAIL b2b_pc4D c%0d got %h exp %h", k + 1, bus.PCplus4D, k); end
        checks++; if (bus.count !== 2'd1) begin errors++; $display("FAIL b2b_count c%0d got %0d exp 1", k + 1, bus.count); end
      end else begin
        checks++; if (bus.validD !== 1'b0) begin errors++; $display("FAIL b2b_validD c1 got %b exp 0", bus.validD); end
      end
    end
    set_in(1'b0, 32'h0, 32'hA8, 1'b0, 1'b0);
    tick;
    tick;
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL b2b_drain got %0d exp 0", bus.count); end
  endtask

  task automatic test_backpressure;
    do_reset;
    set_in(1'b1, 32'd1, 32'h0, 1'b0, 1'b0); tick;
    set_in(1'b1, 32'd2, 32'hA1, 1'b0, 1'b0); tick;
    set_in(1'b0, 32'd0, 32'hA2, 1'b1, 1'b0); #1;
    checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c2 got %b exp 0", bus.fetch_ready); end
    tick;
    set_in(1'b0, 32'd0, 32'h0, 1'b1, 1'b0); #1;
    checks++; if (bus.count !== 2'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", bus.count); end
    checks++; if (bus.fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", bus.fetch_ready); end
    checks++; if (bus.instrD !== 32'hA1) begin errors++; $display("FAIL bp_hold1 got %h exp a1", bus.instrD); end
    tick;
    tick;
    checks++; if (bus.instrD !== 32'hA1) begin errors++; $display("FAIL bp_hold2 got %h exp a1", bus.instrD); end
    set_in(1'b1, 32'd3, 32'h0, 1'b0, 1'b0); #1;
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got %b exp 1", bus.fetch_ready); end
    tick;
    set_in(1'b0, 32'd0, 32'hA3, 1'b0, 1'b0);
    checks++; if (bus.instrD !== 32'hA2) begin errors++; $display("FAIL bp_second got %h exp a2", bus.instrD); end
    checks++; if (bus.PCplus4D !== 32'd2) begin errors++; $display("FAIL bp_second_pc4 got %h exp 2", bus.PCplus4D); end
    tick;
    set_in(1'b0, 32'd0, 32'h0, 1'b0, 1'b0);
    checks++; if (bus.instrD !== 32'hA3) begin errors++; $display("FAIL bp_third got %h exp a3", bus.instrD); end
    checks++; if (bus.PCplus4D !== 32'd3) begin errors++; $display("FAIL bp_third_pc4 got %h exp 3", bus.PCplus4D); end
    checks++; if (bus.count !== 2'd1) begin errors++; $display("FAIL bp_third_count got %0d exp 1", bus.count); end
    tick;
    checks++; if (bus.validD !== 1'b0 || bus.instrD !== 32'h0) begin errors++; $display("FAIL bp_empty got v=%b i=%h exp v=0 i=0", bus.validD, bus.instrD); end
  endtask

  task automatic test_flush;
    do_reset;
    set_in(1'b1, 32'd1, 32'h0, 1'b0, 1'b0); tick;
    set_in(1'b1, 32'd2, 32'hA1, 1'b0, 1'b0); tick;
    set_in(1'b0, 32'd0, 32'hA2, 1'b1, 1'b0); tick;
    // Full and stalled: the flush overrides stall and the redirected fetch is taken.
    set_in(1'b1, 32'h41, 32'h0, 1'b1, 1'b1); #1;
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got %b exp 1", bus.fetch_ready); end
    tick;
    set_in(1'b0, 32'd0, 32'hBB, 1'b0, 1'b0);
    checks++; if (bus.validD !== 1'b0) begin errors++; $display("FAIL fl_validD got %b exp 0", bus.validD); end
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL fl_count got %0d exp 0", bus.count); end
    tick;
    set_in(1'b0, 32'd0, 32'h0, 1'b0, 1'b0);
    checks++; if (bus.instrD !== 32'hBB) begin errors++; $display("FAIL fl_instrD got %h exp bb", bus.instrD); end
    checks++; if (bus.PCplus4D !== 32'h41) begin errors++; $display("FAIL fl_pc4D got %h exp 41", bus.PCplus4D); end
    tick;
    // Response arriving in the flush cycle must be squashed.
    set_in(1'b1, 32'd5, 32'h0, 1'b0, 1'b0); tick;
    set_in(1'b0, 32'd0, 32'hCC, 1'b0, 1'b1); tick;
    set_in(1'b0, 32'd0, 32'hDD, 1'b0, 1'b0);
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL fl_squash got %0d exp 0", bus.count); end
    tick;
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL fl_squash_late got %0d exp 0", bus.count); end
  endtask

  task automatic test_overflow;
    do_reset;
    set_in(1'b1, 32'd1, 32'h0, 1'b0, 1'b0); tick;
    set_in(1'b1, 32'd2, 32'hA1, 1'b0, 1'b0); tick;
    set_in(1'b0, 32'd0, 32'hA2, 1'b1, 1'b0); tick;
    set_in(1'b1, 32'h77, 32'h0, 1'b1, 1'b0); tick;
    set_in(1'b0, 32'd0, 32'h0, 1'b0, 1'b0);
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ov_set got %b exp 1", bus.overflow_err); end
    checks++; if (bus.count !== 2'd2) begin errors++; $display("FAIL ov_count got %0d exp 2", bus.count); end
    checks++; if (bus.instrD !== 32'hA1) begin errors++; $display("FAIL ov_head got %h exp a1", bus.instrD); end
    tick;
    checks++; if (bus.count !== 2'd1) begin errors++; $display("FAIL ov_dropped got %0d exp 1", bus.count); end
    checks++; if (bus.instrD !== 32'hA2) begin errors++; $display("FAIL ov_order got %h exp a2", bus.instrD); end
    tick;
    tick;
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ov_sticky got %b exp 1", bus.overflow_err); end
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL ov_drain got %0d exp 0", bus.count); end
  endtask

  // Entered with overflow_err still set from the previous scenario.
  task automatic test_reset_mid;
    set_in(1'b1, 32'd1, 32'h0, 1'b0, 1'b0); tick;
    set_in(1'b1, 32'd2, 32'hA1, 1'b0, 1'b0); tick;
    set_in(1'b1, 32'd3, 32'hA2, 1'b1, 1'b1);
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    set_in(1'b0, 32'd0, 32'hA3, 1'b0, 1'b0); #1;
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL rm_count got %0d exp 0", bus.count); end
    checks++; if (bus.validD !== 1'b0) begin errors++; $display("FAIL rm_validD got %b exp 0", bus.validD); end
    checks++; if (bus.instrD !== 32'h0 || bus.PCplus4D !== 32'h0) begin errors++; $display("FAIL rm_data got i=%h p=%h exp 0", bus.instrD, bus.PCplus4D); end
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL rm_ovf got %b exp 0", bus.overflow_err); end
    checks++; if (bus.fetch_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", bus.fetch_ready); end
    tick;
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL rm_inflight got %0d exp 0", bus.count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET  = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_overflow;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
